// File: rtl/clockdivider_multi.sv
// Multi-channel programmable clock divider / tick generator with shadowed per-channel config.
// Optional CLKDIV_SYNC_EN adds sync_in for phase-aligning all enabled channels.
module clockdivider_multi #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 13,
   parameter int unsigned DEFAULT_DIV = 5000
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [NUM_CH-1:0]                          en,
   input  logic                                       cfg_wr,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]                           cfg_div,
   input  logic                                       cfg_mode,
`ifdef CLKDIV_SYNC_EN
   input  logic                                       sync_in,
`endif
   output logic                                       cfg_ack,
   output logic [NUM_CH-1:0]                          clk_div,
   output logic [NUM_CH-1:0]                          tick
);

   typedef enum logic {MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1} mode_e;

   logic w_sync;
   logic r_ack;

`ifdef CLKDIV_SYNC_EN
   assign w_sync = sync_in;
`else
   assign w_sync = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ack <= 1'b0;
      else        r_ack <= cfg_wr;
   end

   assign cfg_ack = r_ack;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_div;
      logic [CNT_W-1:0] r_sh_div;
      mode_e            r_mode;
      mode_e            r_sh_mode;
      logic             r_pend;
      logic             r_clk;
      logic             r_tick;
      logic             w_sel;
      logic             w_hold;
      logic             w_last;
      logic             w_apply;

      assign w_sel   = cfg_wr && (int'(cfg_ch) == g);
      // Disabled, halted (D=0) and sync-forced channels share one path: cleared, config applies at once.
      assign w_hold  = !en[g] || w_sync || (r_div == '0);
      assign w_last  = (r_cnt >= r_div - CNT_W'(1));
      assign w_apply = r_pend && (w_hold || w_last);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt     <= '0;
            r_div     <= CNT_W'(DEFAULT_DIV);
            r_mode    <= MODE_TOGGLE;
            r_sh_div  <= '0;
            r_sh_mode <= MODE_TOGGLE;
            r_pend    <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
         end else begin
            if (w_sel) begin
               r_sh_div  <= cfg_div;
               r_sh_mode <= mode_e'(cfg_mode);
            end
            // A write landing on the apply cycle stays pending for the following boundary.
            if (w_apply) begin
               r_div  <= r_sh_div;
               r_mode <= r_sh_mode;
               r_pend <= w_sel;
            end else if (w_sel) begin
               r_pend <= 1'b1;
            end

            if (w_hold) begin
               r_cnt  <= '0;
               r_clk  <= 1'b0;
               r_tick <= 1'b0;
            end else begin
               r_tick <= w_last;
               if (w_last) begin
                  r_cnt <= '0;
                  r_clk <= (w_apply || (r_mode == MODE_PULSE)) ? 1'b0 : ~r_clk;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_mode == MODE_PULSE) r_clk <= 1'b0;
               end
            end
         end
      end

      assign clk_div[g] = r_clk;
      assign tick[g]    = r_tick;
   end

endmodule
